fft_frame_ctrl: RTL
===================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter FRAME_LEN, 4096, samples per FFT frame; power of two, range 8..65536.
REQ-002 Parameter CFG_WORD, 8'h01, word sent once on the FFT config channel (bit0=1 forward transform).
REQ-003 Parameter MAX_INFLIGHT, 2, frames allowed started-but-not-yet-output; range 1..3.
REQ-004 clk  in  1  system clock; all logic is on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  permits new frames to start.
REQ-007 sample  in  16  unsigned (offset-binary) audio sample.
REQ-008 sample_ready  in  1  one-cycle strobe; sample is valid this cycle.
REQ-009 cfg_tdata  out  8  FFT config channel data.
REQ-010 cfg_tvalid  out  1  FFT config channel valid.
REQ-011 cfg_tready  in  1  FFT config channel ready.
REQ-012 s_tdata  out  32  FFT input {imag[31:16]=0, real[15:0]}.
REQ-013 s_tvalid / s_tlast  out  1 each  FFT input stream valid / last.
REQ-014 s_tready  in  1  FFT input stream ready.
REQ-015 m_tvalid, m_tready, m_tlast  in  1 each  FFT output stream, monitored only.
REQ-016 frame_done  out  1  one-cycle pulse when an output frame completes.
REQ-017 drop_cnt  out  16  dropped-sample count, saturating.
REQ-018 busy  out  1  high while inflight count is nonzero.

Function
REQ-019 The FSM SHALL have states CFG and RUN; CFG is entered on reset.
REQ-020 In CFG: cfg_tvalid=1 and cfg_tdata=CFG_WORD; on cfg_tvalid&cfg_tready -> RUN next cycle, cfg_tvalid=0 from then on.
REQ-021 In CFG: every sample_ready strobe is dropped and counted.
REQ-022 Sign conversion: real = sample with MSB inverted (sample - 32768); imag = 0.
REQ-023 A one-entry holding register drives s_tdata/s_tlast; s_tvalid = holding register full.
REQ-024 Latency: a sample accepted on cycle N appears with s_tvalid=1 on cycle N+1.
REQ-025 s_tdata/s_tlast SHALL stay stable while s_tvalid=1 and s_tready=0.
REQ-026 Index counter idx (log2(FRAME_LEN) bits) increments on each s_tvalid&s_tready and wraps FRAME_LEN-1 -> 0.
REQ-027 s_tlast = 1 exactly for the sample loaded at idx = FRAME_LEN-1.
REQ-028 Accept in RUN when sample_ready and (register empty, or draining this cycle via s_tready) and frame-start gate is open.
REQ-029 Frame-start gate: at idx=0, open only if enable=1 and inflight<MAX_INFLIGHT; at idx!=0 always open, so a started frame always completes.
REQ-030 sample_ready with register full and not draining -> sample dropped, drop_cnt+1.
REQ-031 sample_ready blocked by inflight=MAX_INFLIGHT -> dropped, drop_cnt+1; blocked by enable=0 -> discarded, not counted.
REQ-032 drop_cnt saturates at 16'hFFFF.
REQ-033 inflight +1 when a sample with idx=0 is accepted; -1 on m_tvalid&m_tready&m_tlast; both same cycle -> unchanged; never below 0.
REQ-034 frame_done pulses the cycle after each m_tvalid&m_tready&m_tlast.
REQ-035 busy = (inflight != 0), registered.

Reset
REQ-036 rst_n low SHALL asynchronously force: state=CFG, cfg_tvalid=0, s_tvalid=0, s_tlast=0, s_tdata=0, idx=0, inflight=0, drop_cnt=0, frame_done=0, busy=0.
REQ-037 cfg_tvalid SHALL rise on the first clock edge after rst_n deasserts.
REQ-038 Reset mid-frame discards the partial frame; the next frame restarts at idx=0 after a new config handshake.

Verification
REQ-039 Reset release, cfg_tready held 0 for 5 cycles then 1 -> cfg_tdata=8'h01, one handshake, state=RUN; 3 strobes during CFG -> drop_cnt=3.
REQ-040 FRAME_LEN=8, s_tready=1, 8 strobes 0x0000..0x0007 -> s_tdata real 0x8000..0x8007, s_tlast only on 8th, busy=1.
REQ-041 s_tready=0, strobes on 3 consecutive cycles -> first held stable, drop_cnt=2; s_tready=1 with simultaneous strobe -> drain and reload in same cycle, no drop.
REQ-042 MAX_INFLIGHT=2, two full frames sent, no m_tlast -> next idx=0 strobe dropped (drop_cnt+1); m_tlast handshake -> frame_done pulse, inflight=1, next frame starts.
REQ-043 enable=0 at idx=3 -> frame finishes to s_tlast; next idx=0 strobes discarded, drop_cnt unchanged.
REQ-044 rst_n pulsed low at idx=5 -> all outputs reset immediately; new config handshake then frame begins at idx=0.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// Feeds 16-bit offset-binary samples into a streaming FFT core as framed complex words.
// One-entry holding register, one cycle latency; samples are dropped when it cannot drain.
module fft_frame_ctrl #(
  parameter int unsigned FRAME_LEN    = 4096,
  parameter logic [7:0]  CFG_WORD     = 8'h01,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] sample,
  input  logic        sample_ready,
  output logic [7:0]  cfg_tdata,
  output logic        cfg_tvalid,
  input  logic        cfg_tready,
  output logic [31:0] s_tdata,
  output logic        s_tvalid,
  output logic        s_tlast,
  input  logic        s_tready,
  input  logic        m_tvalid,
  input  logic        m_tready,
  input  logic        m_tlast,
  output logic        frame_done,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  localparam int unsigned    IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [1:0]     MAX_IF   = 2'(MAX_INFLIGHT);

  typedef enum logic {
    CFG = 1'b0,
    RUN = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             cfg_vld_next;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] load_idx;
  logic [1:0]       inflight;
  logic [1:0]       inflight_next;

  logic             drain;
  logic             room;
  logic             at_start;
  logic             inflight_full;
  logic             gate;
  logic             accept;
  logic             drop;
  logic             out_done;

  assign cfg_tdata = CFG_WORD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CFG;
      cfg_tvalid <= 1'b0;
    end else begin
      state      <= state_next;
      cfg_tvalid <= cfg_vld_next;
    end
  end

  always_comb begin
    state_next   = state;
    cfg_vld_next = 1'b0;
    case (state)
      CFG: begin
        if (cfg_tvalid && cfg_tready) begin
          state_next = RUN;
        end else begin
          cfg_vld_next = 1'b1;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = CFG;
      end
    endcase
  end

  // load_idx is the frame position of a sample loaded this cycle: if the
  // register drains at the same edge, the new sample sits one past idx.
  always_comb begin
    drain         = s_tvalid && s_tready;
    room          = !s_tvalid || s_tready;
    load_idx      = idx + (drain ? IDX_W'(1) : IDX_W'(0));
    at_start      = (load_idx == '0);
    inflight_full = (inflight >= MAX_IF);
    gate          = !at_start || (enable && !inflight_full);
    accept        = (state == RUN) && sample_ready && room && gate;
    // A closed enable silently discards; only capacity limits count as drops.
    drop          = sample_ready && ((state != RUN) || !room ||
                                     (at_start && enable && inflight_full));
    out_done      = m_tvalid && m_tready && m_tlast;
  end

  always_comb begin
    inflight_next = inflight;
    if ((accept && at_start) && !(out_done && inflight != 2'd0)) begin
      inflight_next = inflight + 2'd1;
    end else if (!(accept && at_start) && out_done && inflight != 2'd0) begin
      inflight_next = inflight - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_tvalid <= 1'b0;
      s_tdata  <= 32'h0;
      s_tlast  <= 1'b0;
      idx      <= '0;
    end else begin
      if (accept) begin
        s_tvalid <= 1'b1;
        s_tdata  <= {16'h0000, ~sample[15], sample[14:0]};
        s_tlast  <= (load_idx == LAST_IDX);
      end else if (drain) begin
        s_tvalid <= 1'b0;
      end
      if (drain) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight   <= 2'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= 16'h0;
    end else begin
      inflight   <= inflight_next;
      busy       <= (inflight_next != 2'd0);
      frame_done <= out_done;
      if (drop && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule
